addsub_serial: RTL and testbench



---
 rtl/addsub_serial.sv | 95 +++++++++
 tb/tb_addsub_serial.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle over WIDTH/DIGIT cycles,
// with valid/ready handshakes on input and output, carry/no-borrow and signed overflow.
module addsub_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             out_ovf
);

  localparam int unsigned Digits = WIDTH / DIGIT;
  localparam int unsigned CntW   = (Digits > 1) ? $clog2(Digits) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  res_q;
  logic              carry_q;
  logic [CntW-1:0]   cnt_q;

  logic [DIGIT:0]    dsum;
  logic [WIDTH-1:0]  res_next;
  logic              last;
  logic              dig_ovf;

  always_comb begin
    dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // Sum digits enter from the MSB side; written as a shift so DIGIT == WIDTH needs no slice.
    res_next = WIDTH'({dsum[DIGIT-1:0], res_q} >> DIGIT);
    last     = (cnt_q == CntW'(Digits - 1));
    // On the final digit the operand MSBs sit at DIGIT-1 after all prior shifts.
    dig_ovf  = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (dsum[DIGIT-1] != a_q[DIGIT-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      out_ovf   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= in_a;
            b_q      <= in_sub ? ~in_b : in_b;
            carry_q  <= in_sub;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= StBusy;
          end
        end
        StBusy: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          res_q   <= res_next;
          carry_q <= dsum[DIGIT];
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            out       <= {dsum[DIGIT], res_next};
            out_ovf   <= dig_ovf;
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: five instances of different geometry, a queue-based scoreboard
// and a monitor that checks result, overflow, latency and hold-while-stalled behaviour.
module tb_addsub_serial;

  localparam int N = 5;

  function automatic int w_of(int g);
    case (g)
      0, 1, 2: return 8;
      3:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int d_of(int g);
    case (g)
      0:       return 2;
      1:       return 1;
      2:       return 8;
      3:       return 4;
      default: return 2;
    endcase
  endfunction

  typedef struct packed {
    logic [32:0] res;
    logic        ovf;
    logic [31:0] cyc;
  } exp_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [8:0] res;
    logic       ovf;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    a_bus = '0;
  logic [31:0]    b_bus = '0;
  logic           sub = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   out_ready = '1;
  logic [N-1:0]   in_ready;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   o_ovf;
  logic [32:0]    o_res [N];

  int unsigned    cyc = 0;
  int             checks = 0;
  int             errors = 0;
  exp_t           exp_q [N][$];
  logic [N-1:0]   prev_valid = '0;
  logic [32:0]    hold_res [N];
  logic [N-1:0]   hold_ovf = '0;
  vec_t           vecs [7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned W = w_of(g);
    localparam int unsigned D = d_of(g);
    logic [W:0] o;
    addsub_serial #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_a      (a_bus[W-1:0]),
      .in_b      (b_bus[W-1:0]),
      .in_sub    (sub),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out       (o),
      .out_ovf   (o_ovf[g])
    );
    assign o_res[g] = 33'(o);
  end

  // Reference: plain integer arithmetic; overflow from the signed result's range.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic s);
    longint m, am, bm, sa, sb, r, lim;
    exp_t e;
    m   = (longint'(1) << w) - 1;
    am  = longint'(a) & m;
    bm  = longint'(b) & m;
    sa  = am[w-1] ? am - (longint'(1) << w) : am;
    sb  = bm[w-1] ? bm - (longint'(1) << w) : bm;
    lim = longint'(1) << (w - 1);
    r   = s ? sa - sb : sa + sb;
    e.ovf = (r < -lim) || (r >= lim);
    if (s) e.res = 33'((am - bm) & m) | ((am >= bm) ? 33'(longint'(1) << w) : 33'd0);
    else   e.res = 33'(am + bm);
    e.cyc = '0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] mask, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [32:0] hres, input logic hovf,
                       input bit use_hand, input bit push);
    int   n = 0;
    exp_t e;
    while (((in_ready & mask) != mask) && (n < 200)) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready %b, expected %b", in_ready, mask);
      return;
    end
    a_bus    = a;
    b_bus    = b;
    sub      = s;
    in_valid = mask;
    tick();
    in_valid = '0;
    if (push) begin
      for (int g = 0; g < N; g++) begin
        if (mask[g]) begin
          if (use_hand && g == 0) begin
            e.res = hres;
            e.ovf = hovf;
          end else begin
            e = model(w_of(g), a, b, s);
          end
          e.cyc = cyc;
          exp_q[g].push_back(e);
        end
      end
    end
  endtask

  task automatic drain();
    int  n = 0;
    bit  busy = 1'b1;
    while (busy && n < 300) begin
      busy = 1'b0;
      for (int g = 0; g < N; g++) if (exp_q[g].size() != 0) busy = 1'b1;
      if (busy) begin
        tick();
        n++;
      end
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: results still pending after %0d cycles, expected none", n);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
          if (out_valid[g]) begin
            if (!prev_valid[g]) begin
              if (exp_q[g].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result[%0d]: got out %h, expected no result", g,
                         o_res[g]);
              end else begin
                chk($sformatf("latency[%0d]", g), 33'(cyc - exp_q[g][0].cyc), 33'(d_of(g) == 0 ?
                    0 : w_of(g) / d_of(g)));
              end
              hold_res[g] = o_res[g];
              hold_ovf[g] = o_ovf[g];
            end else begin
              chk($sformatf("hold_out[%0d]", g), o_res[g], hold_res[g]);
              chk($sformatf("hold_ovf[%0d]", g), 33'(o_ovf[g]), 33'(hold_ovf[g]));
            end
            if (out_ready[g] && exp_q[g].size() != 0) begin
              exp_t e;
              e = exp_q[g].pop_front();
              chk($sformatf("out[%0d]", g), o_res[g], e.res);
              chk($sformatf("ovf[%0d]", g), 33'(o_ovf[g]), 33'(e.ovf));
            end
          end
          prev_valid[g] = out_valid[g];
        end
      end
    join_none

    vecs = '{'{8'hFF, 8'h01, 1'b0, 9'h100, 1'b0},
             '{8'h05, 8'h03, 1'b1, 9'h102, 1'b0},
             '{8'h03, 8'h05, 1'b1, 9'h0FE, 1'b0},
             '{8'h00, 8'h00, 1'b1, 9'h100, 1'b0},
             '{8'h7F, 8'h01, 1'b0, 9'h080, 1'b1},
             '{8'h80, 8'h01, 1'b1, 9'h17F, 1'b1},
             '{8'h80, 8'h80, 1'b0, 9'h100, 1'b1}};

    rst = 1'b1;
    repeat (3) tick();
    chk("reset_in_ready", 33'(in_ready), 33'({N{1'b1}}));
    chk("reset_out_valid", 33'(out_valid), 33'd0);
    chk("reset_out", o_res[0], 33'd0);
    chk("reset_ovf", 33'(o_ovf), 33'd0);
    rst = 1'b0;
    tick();

    // Hand-computed 8-bit vectors on the (8,2) instance.
    for (int i = 0; i < 7; i++) begin
      issue(5'b00001, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].s, 33'(vecs[i].res), vecs[i].ovf,
            1'b1, 1'b1);
      drain();
    end

    // Backpressure: stall five cycles while a second request is offered.
    out_ready[0] = 1'b0;
    issue(5'b00001, 32'h12, 32'h34, 1'b0, 33'h046, 1'b0, 1'b1, 1'b1);
    for (int n = 0; n < 50 && !out_valid[0]; n++) tick();
    chk("bp_out_valid", 33'(out_valid[0]), 33'd1);
    a_bus       = 32'hAA;
    b_bus       = 32'h55;
    in_valid[0] = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("bp_in_ready", 33'(in_ready[0]), 33'd0);
      chk("bp_out", o_res[0], 33'h046);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    chk("bp_release_in_ready", 33'(in_ready[0]), 33'd1);
    chk("bp_release_valid", 33'(out_valid[0]), 33'd0);
    chk("bp_out_held", o_res[0], 33'h046);
    drain();
    issue(5'b00001, 32'h9C, 32'h64, 1'b1, 33'h138, 1'b1, 1'b1, 1'b1);
    drain();

    // Reset during the second BUSY cycle aborts the operation.
    issue(5'b00001, 32'h11, 32'h22, 1'b0, 33'h0, 1'b0, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 33'(in_ready[0]), 33'd1);
    chk("abort_out_valid", 33'(out_valid[0]), 33'd0);
    chk("abort_out", o_res[0], 33'd0);
    chk("abort_ovf", 33'(o_ovf[0]), 33'd0);
    repeat (10) tick();
    issue(5'b00001, 32'h20, 32'h22, 1'b0, 33'h042, 1'b0, 1'b1, 1'b1);
    drain();

    // All geometries: boundary operands, then random operands.
    issue('1, 32'h0000_0000, 32'h0000_0000, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    issue('1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    issue('1, 32'h8000_8080, 32'h0000_0001, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    issue('1, 32'h7FFF_7F7F, 32'h0000_0001, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    issue('1, 32'h8000_8080, 32'h8000_8080, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    issue('1, 32'h0000_0003, 32'h0000_0005, 1'b1, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      issue('1, $urandom, $urandom, 1'($urandom_range(0, 1)), '0, 1'b0, 1'b0, 1'b1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
